// File: rtl/ula_seq_ctrl_if.sv
// Command/result bundle between the operand muxes and the ALU sequencer.
// The master issues commands; the slave (the sequencer) returns results and flags.
interface ula_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               cmd;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         op;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               overflow;
  logic               cout;
  logic               zero;

  modport master (
    output start, cmd, a, b, op,
    input  busy, done, result, overflow, cout, zero
  );

  modport slave (
    input  start, cmd, a, b, op,
    output busy, done, result, overflow, cout, zero
  );
endinterface

// File: rtl/ula_seq_ctrl.sv
// Sequencer around the 8-bit ripple ALU: single-cycle ALU ops plus an 8-cycle
// unsigned shift-add multiply that reuses the same adder for every partial sum.

module ula_of_infinity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             overflow_o
);
  logic [WIDTH-1:0] aEff;
  logic [WIDTH-1:0] bEff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic             setLess;

  // bnegate doubles as carry-in, so SUB/SLT are a + ~b + 1 through the same ripple chain.
  always_comb begin
    aEff     = a_i ^ {WIDTH{op_i[3]}};
    bEff     = b_i ^ {WIDTH{op_i[2]}};
    carry    = '0;
    sum      = '0;
    carry[0] = op_i[2];
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = aEff[i] ^ bEff[i] ^ carry[i];
      carry[i+1] = (aEff[i] & bEff[i]) | (aEff[i] & carry[i]) | (bEff[i] & carry[i]);
    end
    overflow_o = carry[WIDTH] ^ carry[WIDTH-1];
    cout_o     = carry[WIDTH];
    setLess    = sum[WIDTH-1] ^ overflow_o;
    case (op_i[1:0])
      2'b00:   result_o = aEff & bEff;
      2'b01:   result_o = aEff | bEff;
      2'b10:   result_o = sum;
      default: result_o = {{(WIDTH-1){1'b0}}, setLess};
    endcase
  end
endmodule

module ula_seq_ctrl #(
  parameter int WIDTH     = 8,
  parameter int MUL_ITERS = 8
) (
  input  logic          clk,
  input  logic          rst,
  ula_seq_ctrl_if.slave bus
);
  localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [3:0] OP_ADD = 4'b0010;

  generate
    if (WIDTH != 8 || MUL_ITERS != WIDTH) begin : gBadParams
      $error("ula_seq_ctrl: WIDTH must be 8 and MUL_ITERS must equal WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   pHi_q;
  logic [WIDTH-1:0]   pLo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] result_q;
  logic               overflow_q;
  logic               cout_q;
  logic               zero_q;

  logic               mulActive;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   aluA;
  logic [WIDTH-1:0]   aluB;
  logic [3:0]         aluOp;
  logic [WIDTH-1:0]   aluResult;
  logic               aluCout;
  logic               aluOverflow;
  logic               accept;
  logic               lastIter;
  logic [2*WIDTH-1:0] prodNext;

  ula_of_infinity #(.WIDTH(WIDTH)) uAlu (
    .a_i       (aluA),
    .b_i       (aluB),
    .op_i      (aluOp),
    .result_o  (aluResult),
    .cout_o    (aluCout),
    .overflow_o(aluOverflow)
  );

  assign accept   = (state_q == IDLE) && bus.start;
  assign lastIter = (cnt_q == CNT_W'(MUL_ITERS - 1));

  // Partial product step: the carry into P_hi bit 8 comes straight from the ALU.
  assign prodNext = pLo_q[0] ? {aluCout, aluResult, pLo_q[WIDTH-1:1]}
                             : {1'b0, pHi_q, pLo_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = bus.cmd ? MUL : DONE;
        end
      end
      MUL: begin
        if (lastIter) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In MUL the ALU is stolen from the operand inputs to accumulate P_hi + multiplicand.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mulActive = 1'b0;
    case (state_q)
      MUL: begin
        busy      = 1'b1;
        mulActive = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
    aluA  = mulActive ? pHi_q   : bus.a;
    aluB  = mulActive ? mcand_q : bus.b;
    aluOp = mulActive ? OP_ADD  : bus.op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q    <= '0;
      pHi_q      <= '0;
      pLo_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b0;
    end else if (accept) begin
      if (bus.cmd) begin
        mcand_q <= bus.a;
        pHi_q   <= '0;
        pLo_q   <= bus.b;
        cnt_q   <= '0;
      end else begin
        result_q   <= {{WIDTH{1'b0}}, aluResult};
        overflow_q <= aluOverflow;
        cout_q     <= aluCout;
        zero_q     <= (aluResult == '0);
      end
    end else if (mulActive) begin
      {pHi_q, pLo_q} <= prodNext;
      cnt_q          <= cnt_q + CNT_W'(1);
      if (lastIter) begin
        result_q   <= prodNext;
        overflow_q <= 1'b0;
        cout_q     <= |prodNext[2*WIDTH-1:WIDTH];
        zero_q     <= (prodNext == '0);
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;
  assign bus.cout     = cout_q;
  assign bus.zero     = zero_q;
endmodule

// File: doc/ula_seq_ctrl.md
Name: ula_seq_ctrl

Overview:
- Sequencer wrapped around one instance of the team's 8-bit ripple ALU (ula_of_infinity).
- Accepts a command via a start/done handshake and runs one of two operations:
  - a single-cycle ALU operation, passed through and registered;
  - an 8-cycle unsigned shift-add multiply, 8x8->16, that reuses the same ALU for every partial-sum add.
- Sits between the register file / operand muxes and the ALU, so one adder serves both arithmetic and multiply.

Parameters:
- WIDTH, 8, operand width. Fixed by the ALU; any other value is illegal and must be flagged by an elaboration check.
- MUL_ITERS, 8, multiply iteration count. Must equal WIDTH.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  command request; sampled only in IDLE
- cmd  in  1  0 = single ALU op, 1 = unsigned multiply
- a  in  8  operand A (multiplicand for multiply)
- b  in  8  operand B (multiplier for multiply)
- op  in  4  ALU opcode for cmd=0: {ainvert, bnegate/cin, sel[1:0]}; 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR. Ignored for cmd=1.
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, result/flags valid
- result  out  16  cmd=0: {8'h00, alu_result}; cmd=1: product
- overflow  out  1  cmd=0: ALU overflow; cmd=1: 0
- cout  out  1  cmd=0: ALU carry out; cmd=1: 1 if product[15:8] != 0
- zero  out  1  1 if result == 0

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, result=0, overflow=0, cout=0, zero=0.
  - Reset wins over every other input.
  - Reset mid-multiply abandons the operation; no done pulse is produced.
- States: IDLE, MUL, DONE.
- ALU input mux:
  - In IDLE the ALU sees a, b, op.
  - In MUL the ALU sees a = P_hi, b = mcand_q, op = 4'b0010 (ADD).
- IDLE, start=1, cmd=0 (accept edge k):
  - ALU outputs are registered into result[7:0]/overflow/cout/zero at edge k; result[15:8]=0.
  - State -> DONE; done=1 during cycle k+1. Latency is 1 cycle.
- IDLE, start=1, cmd=1 (accept edge k):
  - Load mcand_q = a, P_hi = 0, P_lo = b, iteration counter = 0.
  - State -> MUL.
- MUL, one iteration per edge (edges k+1 .. k+8):
  - If P_lo[0]=1: {P_hi, P_lo} <= {alu_cout, alu_result, P_lo[7:1]}.
  - Else: {P_hi, P_lo} <= {1'b0, P_hi, P_lo[7:1]}.
  - The counter increments each edge. On the edge where counter == MUL_ITERS-1, register result = {final P_hi, P_lo} and flags, then state -> DONE.
  - done=1 during cycle k+9, i.e. 8 MUL cycles after acceptance.
- DONE: done=1 for exactly one cycle, then state -> IDLE. result and flags hold until the next completion or reset.
- busy = 1 in MUL and DONE. start is ignored while busy=1; operand changes during MUL have no effect.
- Back-to-back commands: the earliest next accept is the edge after DONE. Throughput is 1 op per 2 cycles for cmd=0 and 1 per 10 cycles for cmd=1.
- Arithmetic:
  - Multiply is unsigned; product range 0..65025.
  - The carry into bit 8 of P_hi is taken from the ALU cout, not recomputed.
  - The ALU overflow output is ignored during MUL.
- result[15:8] is always 0 for cmd=0. SLT writes 0 or 1 to result[0].
- start=1 with an undefined op value: the ALU result is passed through unmodified; no error output.

Test Plan:
- cmd=0, op=0010, a=8'h7F, b=8'h01 -> done 1 cycle after accept; result=16'h0080, overflow=1, cout=0, zero=0.
- cmd=0, op=0110, a=8'h05, b=8'h05 -> result=16'h0000, zero=1, cout=1. Then op=0111, a=3, b=5 -> result=16'h0001.
- cmd=1, a=8'hFF, b=8'hFF -> busy high 9 cycles, done pulse at accept+9; result=16'hFE01, cout=1, overflow=0, zero=0.
- cmd=1, a=8'h00, b=8'h37 -> result=16'h0000, zero=1, cout=0. Then a=8'h0C, b=8'h0D -> result=16'h009C, cout=0.
- Start multiply a=8'h10, b=8'h10; hold start=1 with a=8'h02, b=8'h03 throughout MUL -> single done; result=16'h0100; second request accepted only after DONE.
- Assert rst on the 4th MUL cycle -> next cycle busy=0, done=0, result=0, no done pulse. A following multiply of 12*13 returns 16'h009C.
